sw_stream_driver: RTL and testbench

Transmit-side companion of the Smith-Waterman array. It holds one 64-base reference and one 48-base query written by a host. On `start` it streams both sequences into the array over the `valid`/`data_ref`/`data_query` interface, waits for the array's `finish` pulse, then captures `max`/`pos_ref`/`pos_query` and presents them to the host with a one-cycle `done` pulse. It sits between the host/control logic and the SW array; a timeout guards against an array that never finishes.

---
 rtl/sw_stream_driver.sv | 223 ++++++++++++++++++++++
 tb/tb_sw_stream_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_stream_driver.sv
// sw_stream_driver
//
// Transmit-side companion of the Smith-Waterman array. A host loads a
// reference sequence and a query sequence (2-bit base codes) while the
// driver is idle. On start the driver streams LEN_REF contiguous beats to
// the array, waits for the array's finish pulse (bounded by TIMEOUT cycles),
// captures the array's result and presents it with a one-cycle done pulse.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   wr_en/wr_sel/        host write port: wr_sel 0 = reference, 1 = query;
//   wr_addr/wr_data      accepted only while idle
//   start                level-sampled transfer request (idle only)
//   busy                 high whenever not idle
//   valid/data_ref/      beat stream to the array (data_query is 0 past
//   data_query           the end of the query)
//   finish/max/          result handshake from the array (WAIT only)
//   pos_ref/pos_query
//   done                 one-cycle pulse when the result is presented
//   timeout, res_*       result registers, held until the next start
//
// All outputs are registered. Sequence memories are not cleared by reset.

module sw_stream_driver #(
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6,
    parameter int LEN_REF         = 64,
    parameter int LEN_QUERY       = 48,
    parameter int TIMEOUT         = 4095
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [5:0]                 wr_addr,
    input  logic [1:0]                 wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       valid,
    output logic [1:0]                 data_ref,
    output logic [1:0]                 data_query,
    input  logic                       finish,
    input  logic [WIDTH_SCORE-1:0]     max,
    input  logic [WIDTH_POS_REF-1:0]   pos_ref,
    input  logic [WIDTH_POS_QUERY-1:0] pos_query,
    output logic                       done,
    output logic                       timeout,
    output logic [WIDTH_SCORE-1:0]     res_max,
    output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
    output logic [WIDTH_POS_QUERY-1:0] res_pos_query
);

    localparam int BW = $clog2(LEN_REF);    // beat index width
    localparam int QW = $clog2(LEN_QUERY);  // query address width

    localparam logic [BW-1:0] LAST_BEAT = BW'(LEN_REF - 1);
    localparam logic [BW:0]   QRY_N     = (BW + 1)'(LEN_QUERY);
    localparam logic [6:0]    REF_N7    = 7'(LEN_REF);
    localparam logic [6:0]    QRY_N7    = 7'(LEN_QUERY);
    localparam logic [11:0]   WAIT_LAST = 12'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_d;

    logic [BW-1:0] beat, beat_d;   // index of the beat currently on the bus
    logic [11:0]   wcnt, wcnt_d;

    logic                       valid_d, done_d, busy_d, timeout_d;
    logic [1:0]                 data_ref_d, data_query_d;
    logic [WIDTH_SCORE-1:0]     res_max_d;
    logic [WIDTH_POS_REF-1:0]   res_pos_ref_d;
    logic [WIDTH_POS_QUERY-1:0] res_pos_query_d;

    logic [1:0] ref_mem   [LEN_REF];
    logic [1:0] query_mem [LEN_QUERY];

    // ------------------------------------------------------------------
    // Sequence storage: host writes land only while idle, so the stream
    // can never see a base change mid-transfer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en) begin
            if (!wr_sel) begin
                if ({1'b0, wr_addr} < REF_N7)
                    ref_mem[wr_addr[BW-1:0]] <= wr_data;
            end else begin
                if ({1'b0, wr_addr} < QRY_N7)
                    query_mem[wr_addr[QW-1:0]] <= wr_data;
            end
        end
    end

    // Read address for the beat that will be on the bus next cycle:
    // beat 0 when launching from IDLE, otherwise the following beat.
    logic [BW-1:0] rd_idx;
    logic [1:0]    rd_ref, rd_qry;

    always_comb begin
        rd_idx = (state == IDLE) ? '0 : beat + 1'b1;
        rd_ref = ref_mem[rd_idx];
        rd_qry = 2'b00;
        // Reference is longer than the query; pad the tail with 0.
        if ({1'b0, rd_idx} < QRY_N)
            rd_qry = query_mem[rd_idx[QW-1:0]];
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Every output is the registered
    // copy of its _d value, so beat k shows up the cycle after the edge
    // that decided it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state;
        beat_d          = beat;
        wcnt_d          = wcnt;
        valid_d         = 1'b0;
        data_ref_d      = 2'b00;
        data_query_d    = 2'b00;
        done_d          = 1'b0;
        busy_d          = busy;
        timeout_d       = timeout;
        res_max_d       = res_max;
        res_pos_ref_d   = res_pos_ref;
        res_pos_query_d = res_pos_query;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d         = SEND;
                    beat_d          = '0;
                    valid_d         = 1'b1;
                    data_ref_d      = rd_ref;
                    data_query_d    = rd_qry;
                    busy_d          = 1'b1;
                    timeout_d       = 1'b0;
                    res_max_d       = '0;
                    res_pos_ref_d   = '0;
                    res_pos_query_d = '0;
                end
            end

            SEND: begin
                if (beat == LAST_BEAT) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end else begin
                    beat_d       = beat + 1'b1;
                    valid_d      = 1'b1;
                    data_ref_d   = rd_ref;
                    data_query_d = rd_qry;
                end
            end

            WAIT: begin
                wcnt_d = wcnt + 1'b1;
                // finish wins over an expiring timeout in the same cycle
                if (finish) begin
                    state_d         = DONE;
                    done_d          = 1'b1;
                    timeout_d       = 1'b0;
                    res_max_d       = max;
                    res_pos_ref_d   = pos_ref;
                    res_pos_query_d = pos_query;
                end else if (wcnt == WAIT_LAST) begin
                    state_d         = DONE;
                    done_d          = 1'b1;
                    timeout_d       = 1'b1;
                    res_max_d       = '0;
                    res_pos_ref_d   = '0;
                    res_pos_query_d = '0;
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            beat          <= '0;
            wcnt          <= '0;
            valid         <= 1'b0;
            data_ref      <= 2'b00;
            data_query    <= 2'b00;
            done          <= 1'b0;
            busy          <= 1'b0;
            timeout       <= 1'b0;
            res_max       <= '0;
            res_pos_ref   <= '0;
            res_pos_query <= '0;
        end else begin
            state         <= state_d;
            beat          <= beat_d;
            wcnt          <= wcnt_d;
            valid         <= valid_d;
            data_ref      <= data_ref_d;
            data_query    <= data_query_d;
            done          <= done_d;
            busy          <= busy_d;
            timeout       <= timeout_d;
            res_max       <= res_max_d;
            res_pos_ref   <= res_pos_ref_d;
            res_pos_query <= res_pos_query_d;
        end
    end

endmodule

// File: tb/tb_sw_stream_driver.sv
// Bench for sw_stream_driver: host writes, beat stream, array result
// handshake, timeout, disturbance during SEND and mid-transfer reset.
// Expected beats come from a plain array copy of what the host wrote.

module tb_sw_stream_driver;
    localparam int LR = 64;
    localparam int LQ = 48;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset, wr_en, wr_sel, start, finish;
    logic [5:0] wr_addr;
    logic [1:0] wr_data;
    logic [7:0] max;
    logic [6:0] pos_ref;
    logic [5:0] pos_query;

    logic       busy, valid, done, timeout;
    logic [1:0] data_ref, data_query;
    logic [7:0] res_max;
    logic [6:0] res_pos_ref;
    logic [5:0] res_pos_query;

    sw_stream_driver #(
        .WIDTH_SCORE(8), .WIDTH_POS_REF(7), .WIDTH_POS_QUERY(6),
        .LEN_REF(LR), .LEN_QUERY(LQ), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .valid(valid),
        .data_ref(data_ref), .data_query(data_query),
        .finish(finish), .max(max), .pos_ref(pos_ref), .pos_query(pos_query),
        .done(done), .timeout(timeout), .res_max(res_max),
        .res_pos_ref(res_pos_ref), .res_pos_query(res_pos_query)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] ref_m [LR];
    logic [1:0] qry_m [LQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host write; only called while the driver is idle, so the model
    // follows the write rules directly.
    task automatic wr(input logic sel, input int addr, input logic [1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(addr); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (!sel) ref_m[addr] = d;
        else if (addr < LQ) qry_m[addr] = d;
    endtask

    // Start sampled at the next edge; results must be cleared right after.
    task automatic launch(input bit hold);
        start = 1'b1;
        tick();
        start = hold;
        chk("start_res_max", 32'(res_max), 0);
        chk("start_timeout", 32'(timeout), 0);
    endtask

    // Check the LR beats. rst_at >= 0 applies reset after that beat.
    // disturb: write, start and finish pulsed during beat 10.
    task automatic beats(input int rst_at, input bit disturb);
        for (int k = 0; k < LR; k++) begin
            chk($sformatf("b%0d_valid", k), 32'(valid), 1);
            chk($sformatf("b%0d_busy", k), 32'(busy), 1);
            chk($sformatf("b%0d_done", k), 32'(done), 0);
            chk($sformatf("b%0d_ref", k), 32'(data_ref), 32'(ref_m[k]));
            chk($sformatf("b%0d_qry", k), 32'(data_query),
                (k < LQ) ? 32'(qry_m[k]) : 0);
            if (k == rst_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk("rst_valid", 32'(valid), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                return;
            end
            if (disturb && k == 10) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd20; wr_data = ~ref_m[20];
                start = 1'b1; finish = 1'b1;
                max = 8'hAA; pos_ref = 7'h11; pos_query = 6'h22;
            end
            tick();
            if (disturb && k == 10) begin
                wr_en = 1'b0; start = 1'b0; finish = 1'b0;
            end
        end
        chk("wait_valid", 32'(valid), 0);
        chk("wait_busy", 32'(busy), 1);
    endtask

    // d WAIT cycles pass before the edge that either samples finish
    // (fin=1) or hits the timeout (fin=0, d = TO-1). Ends back in IDLE.
    task automatic result(input int d, input bit fin,
                          input logic [7:0] m, input logic [6:0] pr, input logic [5:0] pq);
        logic [7:0] em; logic [6:0] epr; logic [5:0] epq;
        for (int i = 0; i < d; i++) begin
            chk("wait_nodone", 32'(done), 0);
            tick();
        end
        if (fin) begin
            finish = 1'b1; max = m; pos_ref = pr; pos_query = pq;
        end
        tick();
        finish = 1'b0;
        em  = fin ? m : 8'd0;
        epr = fin ? pr : 7'd0;
        epq = fin ? pq : 6'd0;
        chk("done", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("timeout", 32'(timeout), fin ? 0 : 1);
        chk("res_max", 32'(res_max), 32'(em));
        chk("res_pos_ref", 32'(res_pos_ref), 32'(epr));
        chk("res_pos_query", 32'(res_pos_query), 32'(epq));
        tick();
        chk("after_done", 32'(done), 0);
        chk("after_busy", 32'(busy), 0);
        chk("hold_res_max", 32'(res_max), 32'(em));
        chk("hold_timeout", 32'(timeout), fin ? 0 : 1);
    endtask

    task automatic rand_result(input int d);
        result(d, 1'b1, 8'($urandom), 7'($urandom), 6'($urandom));
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; finish = 1'b0; max = '0; pos_ref = '0; pos_query = '0;
        tick(); tick();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dref", 32'(data_ref), 0);
        chk("rst_dqry", 32'(data_query), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_res_max", 32'(res_max), 0);
        chk("rst_res_pr", 32'(res_pos_ref), 0);
        chk("rst_res_pq", 32'(res_pos_query), 0);
        reset = 1'b0;
        tick();

        // all-zero sequences, array answers 96/64/48
        for (int k = 0; k < LR; k++) wr(1'b0, k, 2'd0);
        for (int k = 0; k < LQ; k++) wr(1'b1, k, 2'd0);
        launch(1'b0);
        beats(-1, 1'b0);
        result(3, 1'b1, 8'd96, 7'd64, 6'd48);

        // ramp pattern, plus an out-of-range query write that must drop
        for (int k = 0; k < LR; k++) wr(1'b0, k, 2'(k % 4));
        for (int k = 0; k < LQ; k++) wr(1'b1, k, 2'(3 - (k % 4)));
        wr(1'b1, 50, 2'd3);
        wr(1'b1, 63, 2'd1);
        launch(1'b0);
        beats(-1, 1'b0);
        rand_result($urandom_range(0, 5));

        // array never finishes
        launch(1'b0);
        beats(-1, 1'b0);
        result(TO - 1, 1'b0, 8'd0, 7'd0, 6'd0);

        // write/start/finish during SEND must be ignored
        launch(1'b0);
        beats(-1, 1'b1);
        rand_result(2);

        // reset at beat 30, then a clean replay from beat 0
        launch(1'b0);
        beats(30, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("postrst_done", 32'(done), 0);
            chk("postrst_valid", 32'(valid), 0);
            tick();
        end
        launch(1'b0);
        beats(-1, 1'b0);
        rand_result(1);

        // finish arrives in the same cycle the timeout would fire
        launch(1'b0);
        beats(-1, 1'b0);
        result(TO - 1, 1'b1, 8'h5C, 7'h3F, 6'h2A);

        // random contents and array latencies; last runs hold start high
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < LR; k++) wr(1'b0, k, 2'($urandom));
            for (int k = 0; k < LQ; k++) wr(1'b1, k, 2'($urandom));
            launch(1'b0);
            beats(-1, 1'b0);
            rand_result($urandom_range(0, TO - 1));
        end
        launch(1'b1);
        beats(-1, 1'b0);
        rand_result($urandom_range(0, 8));
        // start still high: driver re-launches from IDLE on the next edge
        tick();
        start = 1'b0;
        beats(-1, 1'b0);
        rand_result(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
